lzrw1_decompressor_stream: RTL

LZRW1_DECOMPRESSOR_STREAM -- requirements
Module: lzrw1_decompressor_stream

---
 rtl/lzrw1_pkg.sv | 17 +
 rtl/lzrw1_history_buf.sv | 42 ++++
 rtl/lzrw1_decompressor_stream.sv | 127 ++++++++++++
 3 files changed

// File: rtl/lzrw1_pkg.sv
// Shared definitions for the LZRW1 stream decompressor: FSM states and
// item field positions.
package lzrw1_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LIT,
    COPY
  } state_t;

  localparam int LEN_MSB           = 15;
  localparam int LEN_LSB           = 12;
  localparam int OFF_MSB           = 11;
  localparam int MIN_MATCH_DEFAULT = 3;
  localparam int MAX_OFFSET_WIDTH  = 12;

endpackage

// File: rtl/lzrw1_history_buf.sv
// History window of already emitted bytes: one write port at wr_ptr, one
// combinational read port, plus write pointer and saturating fill level.
module lzrw1_history_buf
  import lzrw1_pkg::*;
#(
  parameter int HISTORY_SIZE = 4096,
  localparam int ADDR_W = $clog2(HISTORY_SIZE)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] fill
);

  logic [7:0] mem [HISTORY_SIZE];

  // Contents survive reset on purpose; fill keeps stale bytes unreachable.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + ADDR_W'(1);
      if (fill != '1) begin
        fill <= fill + ADDR_W'(1);
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lzrw1_decompressor_stream.sv
// LZRW1 item decoder: turns literal/copy items into a byte stream with
// valid/ready backpressure, keeping emitted bytes in a history window.
module lzrw1_decompressor_stream
  import lzrw1_pkg::*;
#(
  parameter int HISTORY_SIZE = 4096,
  parameter int MIN_MATCH    = MIN_MATCH_DEFAULT,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [15:0]            data_in,
  input  logic                   control_word_in,
  input  logic                   data_in_valid,
  output logic                   decompressor_busy,
  output logic [7:0]             decompressed_byte,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   decode_error,
  output logic [COUNT_WIDTH-1:0] byte_count
);

  localparam int OFF_W = $clog2(HISTORY_SIZE);
  localparam int LEN_W = $clog2(16 + MIN_MATCH);

  state_t                      state;
  logic [MAX_OFFSET_WIDTH-1:0] off_field;
  logic [3:0]                  len_code;
  logic [OFF_W-1:0]            offset;
  logic [OFF_W-1:0]            src_ptr;
  logic [OFF_W-1:0]            rd_addr;
  logic [OFF_W-1:0]            wr_ptr;
  logic [OFF_W-1:0]            fill;
  logic [LEN_W-1:0]            remaining;
  logic [7:0]                  rd_data;
  logic [7:0]                  next_copy_byte;
  logic                        off_high_zero;
  logic                        copy_legal;
  logic                        accept;
  logic                        handshake;

  assign off_field     = data_in[OFF_MSB:0];
  assign len_code      = data_in[LEN_MSB:LEN_LSB];
  assign offset        = off_field[OFF_W-1:0];
  assign off_high_zero = (off_field >> OFF_W) == '0;
  assign copy_legal    = off_high_zero && (offset != '0) && (offset <= fill);

  assign decompressor_busy = (state != IDLE);
  assign accept            = data_in_valid && !decompressor_busy;
  assign handshake         = out_valid && out_ready;

  // The byte being written this edge is not yet in memory, so an offset-1
  // copy forwards it straight from the output register.
  assign rd_addr        = (state == COPY) ? src_ptr + OFF_W'(1) : wr_ptr - offset;
  assign next_copy_byte = (rd_addr == wr_ptr) ? decompressed_byte : rd_data;

  lzrw1_history_buf #(
    .HISTORY_SIZE(HISTORY_SIZE)
  ) u_history (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (handshake),
    .wr_data(decompressed_byte),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .wr_ptr (wr_ptr),
    .fill   (fill)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      out_valid         <= 1'b0;
      decompressed_byte <= '0;
      decode_error      <= 1'b0;
      byte_count        <= '0;
      src_ptr           <= '0;
      remaining         <= '0;
    end else begin
      if (handshake) begin
        byte_count <= byte_count + COUNT_WIDTH'(1);
      end
      case (state)
        IDLE: begin
          if (accept) begin
            if (!control_word_in) begin
              state             <= LIT;
              decompressed_byte <= data_in[7:0];
              out_valid         <= 1'b1;
            end else if (copy_legal) begin
              state             <= COPY;
              decompressed_byte <= rd_data;
              out_valid         <= 1'b1;
              src_ptr           <= wr_ptr - offset;
              remaining         <= LEN_W'(len_code) + LEN_W'(MIN_MATCH - 1);
            end else begin
              decode_error <= 1'b1;
            end
          end
        end
        LIT: begin
          if (handshake) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        COPY: begin
          if (handshake) begin
            if (remaining == '0) begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end else begin
              remaining         <= remaining - LEN_W'(1);
              src_ptr           <= src_ptr + OFF_W'(1);
              decompressed_byte <= next_copy_byte;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
